// File: rtl/ecu_ni_tx.sv
// ecu_ni_tx - transmit-side network interface for an ECU.
//
// Buffers complete 131-bit ECU messages in a small FIFO. Each message is
// serialised into a six-flit packet (head + five body flits, the last one
// marked tail) for the local router port. Messages offered while the buffer
// is full are discarded and counted.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   i_data        ECU message: [1:0] control, [129:2] payload, [130] frame flag
//   i_valid       message present on i_data
//   o_ready       buffer can take a message (combinational from full flag)
//   o_flit        [33:32] type (01 head, 00 body, 10 tail), [31:0] data
//   o_flit_valid  o_flit holds a valid flit
//   i_flit_ready  router accepts the flit this cycle
//   o_drop_count  messages dropped on a full buffer, saturates at 255
module ecu_ni_tx #(
  parameter int XCORD      = 0,
  parameter int YCORD      = 0,
  parameter int DATA_WIDTH = 131,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [33:0]           o_flit,
  output logic                  o_flit_valid,
  input  logic                  i_flit_ready,
  output logic [7:0]            o_drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LP_X     = 4'(XCORD);
  localparam logic [3:0]    LP_Y     = 4'(YCORD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY
  } state_t;

  state_t                r_state;
  logic [2:0]            r_k;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_msg;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_tail_xfer;
  logic [DATA_WIDTH-1:0] w_head_msg;
  logic [33:0]           w_head_flit;
  logic [159:0]          w_padded;
  logic [2:0]            w_body_idx;
  logic [31:0]           w_body_data;
  logic [33:0]           w_body_flit;

  assign w_full      = (r_count == LP_DEPTH);
  assign w_empty     = (r_count == '0);
  assign o_ready     = !w_full;
  // Full blocks a push even when a pop frees a slot on the same edge.
  assign w_push      = i_valid && !w_full;
  assign w_tail_xfer = (r_state == S_BODY) && (r_k == 3'd4) && i_flit_ready;
  // Pop when the output register is free: idle, or the tail leaves this edge.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_tail_xfer);
  assign w_head_msg  = r_mem[r_rptr];

  // Head flit: node coordinates, ID byte, body count of five.
  assign w_head_flit = {2'b01, LP_X, LP_Y, w_head_msg[129:122], 13'd0, 3'd5};

  // Message zero-extended to five 32-bit body words.
  assign w_padded    = 160'(r_msg);
  assign w_body_idx  = (r_state == S_HEAD) ? 3'd0 : (r_k + 3'd1);

  always_comb begin
    w_body_data = w_padded[31:0];
    case (w_body_idx)
      3'd1:    w_body_data = w_padded[63:32];
      3'd2:    w_body_data = w_padded[95:64];
      3'd3:    w_body_data = w_padded[127:96];
      3'd4:    w_body_data = w_padded[159:128];
      default: w_body_data = w_padded[31:0];
    endcase
  end

  assign w_body_flit = {(w_body_idx == 3'd4) ? 2'b10 : 2'b00, w_body_data};

  // Storage array needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_drop_count <= '0;
    end else if (i_valid && w_full && (o_drop_count != 8'hFF)) begin
      o_drop_count <= o_drop_count + 8'd1;
    end
  end

  // Serialiser. o_flit only changes on an accepted flit (or a pop while
  // idle), so it holds stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_msg        <= '0;
      o_flit       <= '0;
      o_flit_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_msg        <= w_head_msg;
            o_flit       <= w_head_flit;
            o_flit_valid <= 1'b1;
            r_k          <= '0;
            r_state      <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (i_flit_ready) begin
            o_flit  <= w_body_flit;
            r_k     <= '0;
            r_state <= S_BODY;
          end
        end
        S_BODY: begin
          if (i_flit_ready) begin
            if (r_k == 3'd4) begin
              r_k <= '0;
              // Chain straight into the next head so packets stream without a bubble.
              if (w_pop) begin
                r_msg   <= w_head_msg;
                o_flit  <= w_head_flit;
                r_state <= S_HEAD;
              end else begin
                o_flit       <= '0;
                o_flit_valid <= 1'b0;
                r_state      <= S_IDLE;
              end
            end else begin
              o_flit <= w_body_flit;
              r_k    <= r_k + 3'd1;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          o_flit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ecu_ni_tx.md
# ecu_ni_tx

Transmit-side network interface placed directly downstream of an ECU. It accepts complete 131-bit ECU messages on a valid/ready port and buffers them in a small FIFO. Each message is serialised into a six-flit packet (one head flit, five body flits, the last marked tail) toward the local router port. It also counts messages that the ECU presents while the buffer is full.

## Interface
- XCORD, 0, node x coordinate (4 bits used), inserted in the head flit
- YCORD, 0, node y coordinate (4 bits used), inserted in the head flit
- DATA_WIDTH, 131, ECU message width; fixed at 131 for this block
- FIFO_DEPTH, 4, message buffer depth; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- i_data  in  131  ECU message: [1:0] control, [129:2] 128-bit payload, [130] frame flag (carried transparently)
- i_valid  in  1  message present on i_data
- o_ready  out  1  buffer can accept a message; wired to the ECU's i_ready
- o_flit  out  34  [33:32] type (01 head, 00 body, 10 tail), [31:0] data
- o_flit_valid  out  1  o_flit holds a valid flit
- i_flit_ready  in  1  router accepts the flit this cycle
- o_drop_count  out  8  number of messages dropped because the buffer was full; saturates at 255

## Operation
- Push/accept:
  - o_ready = !full.
  - A message is written when i_valid && !full.
  - The ECU is not required to honour o_ready. If i_valid && full, the message is discarded and o_drop_count increments (saturating at 255).
  - A push is never accepted on a full cycle, even if a pop happens in the same cycle.
- FIFO: FIFO_DEPTH entries of 131 bits, with wrapping read/write pointers and an occupancy count. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states are IDLE, HEAD and BODY. A 3-bit body index k runs from 0 to 4.
  - IDLE: if the FIFO is not empty, pop the head entry into the message register, load the head flit into o_flit, set o_flit_valid, and go to HEAD.
  - HEAD: when the head flit is accepted, load body flit 0, set k=0, and go to BODY.
  - BODY: on each accepted flit, load flit k+1.
  - On the accepted tail (k=4): if the FIFO is not empty, pop the next message and load its head flit on the same edge (stay in HEAD, no bubble). Otherwise clear o_flit_valid and go to IDLE.
- Head flit data:
  - [31:28] = XCORD[3:0]
  - [27:24] = YCORD[3:0]
  - [23:16] = msg[129:122] (ID byte)
  - [15:3] = 0
  - [2:0] = 3'd5 (body count)
- Body flit k:
  - data = padded[32k+31:32k], where padded = {29'b0, msg} (160 bits).
  - type is 00 for k=0..3 and 10 for k=4.
- Output register rules:
  - While o_flit_valid && !i_flit_ready, o_flit and o_flit_valid hold stable.
  - A flit transfers only on o_flit_valid && i_flit_ready.
- Reset (rst==0 at an edge), including mid-packet:
  - FIFO emptied, FSM to IDLE, k=0.
  - o_flit_valid=0, o_flit=0, o_drop_count=0, o_ready=1 from the following cycle.
  - A partially sent packet is abandoned; no tail is emitted.

## Timing
- All outputs are registered except o_ready, which is decoded from the registered full flag.
- Latency:
  - Message written at edge t.
  - The FSM pops it at edge t+1, so the head flit is visible with o_flit_valid=1 after edge t+1.
  - With i_flit_ready held high, the packet occupies six consecutive cycles, and back-to-back packets stream at 6 cycles/message with no idle cycle.
- Throughput bound: one push per cycle on input versus one message per 6 cycles on output. A burst of FIFO_DEPTH+1 messages in consecutive cycles fills the buffer, because the first pop frees a slot only one cycle after its push.
- o_drop_count updates at the edge where the drop occurs.

## Test plan
- Single message, XCORD=1, YCORD=0, i_flit_ready=1. Inputs: i_data[1:0]=0, i_data[129:2]=128'hcb0000000eafac43_800000004b200000, i_data[130]=1, one-cycle i_valid pulse. Required flits in order:
  - {01,32'h10cb0005}
  - {00,32'h2c800000}
  - {00,32'h00000001}
  - {00,32'h3abeb10e}
  - {00,32'h2c000000}
  - {10,32'h00000007}
  
  The head appears 1 cycle after the accepting edge; o_flit_valid drops after the tail.
- Backpressure: toggle i_flit_ready pseudo-randomly. The same six flits must appear in order, with o_flit held stable on every stalled cycle.
- Overflow, FIFO_DEPTH=4: i_flit_ready=0, 6 consecutive valid messages. Required: o_ready falls after the 5th message (one entry already popped to the output register), and o_drop_count=1.
- Back-to-back, i_flit_ready=1: 3 messages. Required: 18 consecutive valid flits, with each tail followed immediately by the next head.
- Reset mid-packet: assert rst=0 during body flit 2. Required: o_flit_valid=0 after that edge, o_drop_count=0, FIFO empty, and no tail emitted. A new message after reset produces a full, correct packet.
- Drop saturation: 300 messages with i_flit_ready=0. Required: o_drop_count stops at 255.
